zbt_wr_buf: RTL

Write-side buffer between the pixel-processing stage and ZBT bank 1. Accepts processed pixel pairs (two 18-bit RGB 6:6:6 pixels in 36 bits) with their 19-bit ZBT word address, queues them in a small FIFO, and issues ZBT writes only in the cycles the bank arbiter grants a write slot. It also generates the pipelined-ZBT data delay, so data reaches the bank a fixed number of cycles after its address and write enable.

---
 rtl/zbt_wr_buf_pkg.sv | 21 ++
 rtl/pix_fifo.sv | 54 +++++
 rtl/zbt_wr_buf.sv | 105 ++++++++++
 3 files changed

// File: rtl/zbt_wr_buf_pkg.sv
// Shared types and constants for the ZBT bank-1 write buffer.
// Entry layout is {data, addr} so one FIFO word carries a whole write.
package zbt_wr_buf_pkg;

  localparam int PIX_PAIR_W  = 36;
  localparam int ZBT_ADDR_W  = 19;
  localparam int ZBT_DAT_LAT = 2;
  localparam int ENTRY_W     = PIX_PAIR_W + ZBT_ADDR_W;

  typedef struct packed {
    logic [PIX_PAIR_W-1:0] data;
    logic [ZBT_ADDR_W-1:0] addr;
  } wr_entry_t;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// Single-clock FIFO of write entries; head is read from pre-edge state.
// Occupancy counter is the single source of full/empty.
module pix_fifo
  import zbt_wr_buf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout,
  output logic               full,
  output logic               empty,
  output logic [AW:0]        level
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + (AW+1)'(1);
      end else if (pop && !push) begin
        cnt <= cnt - (AW+1)'(1);
      end
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign level = cnt;

endmodule

// File: rtl/zbt_wr_buf.sv
// Write-side buffer to ZBT bank 1: queues pixel pairs and issues writes
// in granted slots, with data trailing we/addr by ZBT_DAT_LAT cycles.
module zbt_wr_buf
  import zbt_wr_buf_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int ZBT_DAT_LAT = zbt_wr_buf_pkg::ZBT_DAT_LAT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PIX_PAIR_W-1:0] proc_pix,
  input  logic [ZBT_ADDR_W-1:0] proc_pix_addr,
  input  logic                  pix_valid,
  input  logic                  wr_slot,
  input  logic                  clr_ovf,
  output logic                  zbt_we,
  output logic [ZBT_ADDR_W-1:0] zbt_addr,
  output logic [PIX_PAIR_W-1:0] zbt_data,
  output logic [AW:0]           fifo_level,
  output logic                  overflow,
  output logic [15:0]           drop_cnt
);

  wr_entry_t   din;
  wr_entry_t   head;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        drop;
  logic [AW:0] level;

  logic [PIX_PAIR_W-1:0]  dly_dat [ZBT_DAT_LAT];
  logic [ZBT_DAT_LAT-1:0] dly_vld;

  always_comb begin
    din      = '0;
    din.data = proc_pix;
    din.addr = proc_pix_addr;
  end

  // At full, a push only fits if the head leaves this same edge.
  assign pop  = wr_slot && !empty;
  assign push = pix_valid && (!full || pop);
  assign drop = pix_valid && full && !pop;

  pix_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign fifo_level = level;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zbt_we   <= 1'b0;
      zbt_addr <= '0;
      zbt_data <= '0;
      dly_vld  <= '0;
      for (int i = 0; i < ZBT_DAT_LAT; i++) begin
        dly_dat[i] <= '0;
      end
    end else begin
      zbt_we     <= pop;
      dly_vld[0] <= pop;
      dly_dat[0] <= head.data;
      if (pop) begin
        zbt_addr <= head.addr;
      end
      for (int i = 1; i < ZBT_DAT_LAT; i++) begin
        dly_vld[i] <= dly_vld[i-1];
        dly_dat[i] <= dly_dat[i-1];
      end
      if (dly_vld[ZBT_DAT_LAT-1]) begin
        zbt_data <= dly_dat[ZBT_DAT_LAT-1];
      end
    end
  end

  // A drop in the clear cycle restarts the count at one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= clr_ovf ? 16'd1 : sat_inc16(drop_cnt);
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule
